// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: word widths, write-back select codes, MEM-stage
// FSM state codes and small helpers for access classification and WB muxing.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_RSVD = 2'b11;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_RESP = 1'b1;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_class_t;

    // Store enable wins over a load-style write-back select.
    function automatic acc_class_t classify(input logic we_dmem, input logic [1:0] wbsel);
        if (we_dmem)
            return ACC_STORE;
        else if (wbsel == WB_DMEM)
            return ACC_LOAD;
        else
            return ACC_NONE;
    endfunction

    function automatic logic [XLEN-1:0] wb_select(
        input logic [1:0]      wbsel,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] rdata
    );
        case (wbsel)
            WB_DMEM:         return rdata;
            WB_PC4:          return pc + XLEN'(4);
            WB_ALU, WB_RSVD: return alu;
            default:         return alu;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Word-wide request/grant/response data-memory port. The MEM stage is master.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: selects write-back data and inserts a bubble
// whenever the MEM stage stalls.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bubble,
    input  logic                 kill,
    input  logic                 we_reg,
    input  logic [REG_IDX_W-1:0] rdst_id,
    input  logic [1:0]           wbsel,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rdata,
    output logic                 wb_we_reg,
    output logic [REG_IDX_W-1:0] wb_rdst_id,
    output logic [XLEN-1:0]      wb_wdata
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            wb_we_reg  <= 1'b0;
            wb_rdst_id <= '0;
            wb_wdata   <= '0;
        end else begin
            // A suppressed (misaligned) access still retires, but never writes.
            wb_we_reg  <= we_reg & ~kill;
            wb_rdst_id <= rdst_id;
            wb_wdata   <= wb_select(wbsel, alu_result, pc, rdata);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: request/grant/response sequencing,
// pipeline stall generation, stall counter and the MEM/WB register.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | no access outstanding; aligned load/store drives dmem_req
//   ST_WAIT_RESP | load granted, waiting for dmem_rvalid
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_we_reg,
    input  logic                 mem_we_dmem,
    input  logic [XLEN-1:0]      mem_pc,
    input  logic [XLEN-1:0]      mem_rd,
    input  logic [XLEN-1:0]      mem_rs2,
    input  logic [REG_IDX_W-1:0] mem_rdst_id,
    input  logic [1:0]           mem_wbsel,
    dmem_if.master               dmem,
    output logic                 mem_stall,
    output logic                 misalign,
    output logic                 wb_we_reg,
    output logic [REG_IDX_W-1:0] wb_rdst_id,
    output logic [XLEN-1:0]      wb_wdata,
    output logic [31:0]          stall_cnt
);

    logic [0:0] state_q;
    logic [0:0] state_d;
    acc_class_t acc;
    logic       mem_op;
    logic       aligned;
    logic       access_ok;
    logic       in_idle;

    always_comb begin
        acc       = classify(mem_we_dmem, mem_wbsel);
        mem_op    = (acc != ACC_NONE);
        aligned   = (mem_rd[1:0] == 2'b00);
        access_ok = mem_op & aligned;
        in_idle   = (state_q == ST_IDLE);
    end

    // Request is held with the frozen EX/MEM values until granted.
    assign dmem.dmem_req   = ~rst & in_idle & access_ok;
    assign dmem.dmem_we    = (acc == ACC_STORE);
    assign dmem.dmem_addr  = mem_rd[ADDR_W-1:0];
    assign dmem.dmem_wdata = mem_rs2[DATA_W-1:0];

    assign mem_stall = (in_idle & access_ok & ((acc == ACC_LOAD) | ~dmem.dmem_gnt))
                     | (~in_idle & ~dmem.dmem_rvalid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (access_ok && (acc == ACC_LOAD) && dmem.dmem_gnt)
                    state_d = ST_WAIT_RESP;
            ST_WAIT_RESP:
                if (dmem.dmem_rvalid)
                    state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            misalign <= in_idle & mem_op & ~aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (mem_stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble     (mem_stall),
        .kill       (mem_op & ~aligned),
        .we_reg     (mem_we_reg),
        .rdst_id    (mem_rdst_id),
        .wbsel      (mem_wbsel),
        .alu_result (mem_rd),
        .pc         (mem_pc),
        .rdata      (dmem.dmem_rdata),
        .wb_we_reg  (wb_we_reg),
        .wb_rdst_id (wb_rdst_id),
        .wb_wdata   (wb_wdata)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: every driven cycle pushes the expected
// MEM/WB contents, which a monitor pops and compares after the next clock edge.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_we_reg;
    logic        mem_we_dmem;
    logic [31:0] mem_pc;
    logic [31:0] mem_rd;
    logic [31:0] mem_rs2;
    logic [4:0]  mem_rdst_id;
    logic [1:0]  mem_wbsel;
    logic        mem_stall;
    logic        misalign;
    logic        wb_we_reg;
    logic [4:0]  wb_rdst_id;
    logic [31:0] wb_wdata;
    logic [31:0] stall_cnt;

    dmem_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_we_reg  (mem_we_reg),
        .mem_we_dmem (mem_we_dmem),
        .mem_pc      (mem_pc),
        .mem_rd      (mem_rd),
        .mem_rs2     (mem_rs2),
        .mem_rdst_id (mem_rdst_id),
        .mem_wbsel   (mem_wbsel),
        .dmem        (dmem),
        .mem_stall   (mem_stall),
        .misalign    (misalign),
        .wb_we_reg   (wb_we_reg),
        .wb_rdst_id  (wb_rdst_id),
        .wb_wdata    (wb_wdata),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rdst;
        logic [31:0] wdata;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cnt_model = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic [4:0] rdst, input logic [31:0] wdata,
                            input logic mis);
        exp_t e;
        e.we = we; e.rdst = rdst; e.wdata = wdata; e.mis = mis; e.cnt = cnt_model;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("wb_we_reg",  32'(wb_we_reg),  32'(e.we));
                check_val("wb_rdst_id", 32'(wb_rdst_id), 32'(e.rdst));
                check_val("wb_wdata",   wb_wdata,        e.wdata);
                check_val("misalign",   32'(misalign),   32'(e.mis));
                check_val("stall_cnt",  stall_cnt,       e.cnt);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst)
            assert (!(dmem.dmem_gnt && dmem.dmem_rvalid))
                else $error("FAIL gnt_rvalid_same_cycle: got 1 expected 0");
    end

    task automatic drive_nop(input logic [31:0] rd, input logic [4:0] rdst);
        mem_we_reg = 1'b0; mem_we_dmem = 1'b0; mem_pc = 32'h0; mem_rd = rd;
        mem_rs2 = 32'h0; mem_rdst_id = rdst; mem_wbsel = 2'b00;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive_nop(32'h0, 5'd0);
            cnt_model = 0;
            push_exp(1'b0, 5'd0, 32'h0, 1'b0);
            #1;
            check_val("rst_req", 32'(dmem.dmem_req), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One EX/MEM instruction, held for as many cycles as the memory makes it stall.
    // Caller must be at a negedge (inputs are driven immediately, no extra wait).
    task automatic run_op(input logic we_reg, input logic we_dmem, input logic [31:0] pc,
                          input logic [31:0] rd, input logic [31:0] rs2, input logic [4:0] rdst,
                          input logic [1:0] wbsel, input int gnt_dly, input int resp_dly,
                          input logic [31:0] rdata);
        logic        is_store, is_load, mem_op, al, stall, req;
        logic [31:0] rdata_drv, wexp;
        int          stall_exp;
        is_store = we_dmem;
        is_load  = !we_dmem && (wbsel == 2'b01);
        mem_op   = is_store || is_load;
        al       = (rd[1:0] == 2'b00);
        if (mem_op && al)
            stall_exp = is_store ? gnt_dly : gnt_dly + 1 + resp_dly;
        else
            stall_exp = 0;
        for (int cyc = 0; cyc <= stall_exp; cyc++) begin
            if (cyc > 0) @(negedge clk);
            rdata_drv = (cyc == stall_exp) ? rdata : ~rdata;
            mem_we_reg = we_reg; mem_we_dmem = we_dmem; mem_pc = pc; mem_rd = rd;
            mem_rs2 = rs2; mem_rdst_id = rdst; mem_wbsel = wbsel;
            dmem.dmem_gnt    = mem_op && al && (cyc == gnt_dly);
            dmem.dmem_rvalid = is_load && al && (cyc == gnt_dly + 1 + resp_dly);
            dmem.dmem_rdata  = rdata_drv;
            stall = (cyc < stall_exp);
            req   = mem_op && al && (cyc <= gnt_dly);
            if (stall) begin
                if (cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 1;
                push_exp(1'b0, 5'd0, 32'h0, 1'b0);
            end else begin
                case (wbsel)
                    2'b01:   wexp = rdata_drv;
                    2'b10:   wexp = pc + 32'd4;
                    default: wexp = rd;
                endcase
                push_exp(we_reg && !(mem_op && !al), rdst, wexp, mem_op && !al);
            end
            #1;
            check_val("mem_stall", 32'(mem_stall), 32'(stall));
            check_val("dmem_req",  32'(dmem.dmem_req), 32'(req));
            if (req) begin
                check_val("dmem_addr",  dmem.dmem_addr,      rd);
                check_val("dmem_we",    32'(dmem.dmem_we),   32'(is_store));
                check_val("dmem_wdata", dmem.dmem_wdata,     rs2);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive_nop(32'h0, 5'd0);
        do_reset(2);
        check_val("reset_stall_cnt", stall_cnt, 32'h0);
        check_val("reset_wb_we", 32'(wb_we_reg), 32'h0);

        // ALU op
        run_op(1'b1, 1'b0, 32'h0, 32'h1234, 32'h0, 5'd5, 2'b00, 0, 0, 32'h0);
        // store, immediate grant
        run_op(1'b0, 1'b1, 32'h40, 32'h100, 32'hDEADBEEF, 5'd0, 2'b00, 0, 0, 32'h0);
        check_val("store_no_stall_cnt", stall_cnt, 32'd0);
        // load, 2-cycle grant delay, 1-cycle response
        run_op(1'b1, 1'b0, 32'h44, 32'h200, 32'h0, 5'd7, 2'b01, 2, 0, 32'hCAFEF00D);
        #1;
        check_val("load_stall_cnt", stall_cnt, 32'd3);
        // misaligned load and store
        run_op(1'b1, 1'b0, 32'h48, 32'h202, 32'h0, 5'd8, 2'b01, 0, 0, 32'h1111_2222);
        run_op(1'b0, 1'b1, 32'h4C, 32'h101, 32'h55AA55AA, 5'd0, 2'b00, 0, 0, 32'h0);
        // JAL-type wrap, reserved select, rd=x0 write
        run_op(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd1, 2'b10, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 32'h50, 32'hABCD, 32'h0, 5'd2, 2'b11, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 32'h54, 32'h55, 32'h0, 5'd0, 2'b00, 0, 0, 32'h0);
        // delayed store, load with long response, back-to-back loads
        run_op(1'b0, 1'b1, 32'h58, 32'h300, 32'h0BADF00D, 5'd0, 2'b00, 2, 0, 32'h0);
        run_op(1'b1, 1'b0, 32'h5C, 32'h304, 32'h0, 5'd9, 2'b01, 0, 2, 32'h1357_9BDF);
        run_op(1'b1, 1'b0, 32'h60, 32'h308, 32'h0, 5'd10, 2'b01, 0, 0, 32'h2468_ACE0);

        for (int i = 0; i < 24; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = {$urandom_range(0, 32'h3FFF), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            case (kind)
                0: run_op(1'b1, 1'b0, $urandom, a, $urandom, 5'($urandom), 2'b00, 0, 0, $urandom);
                1: run_op(1'($urandom), 1'b1, $urandom, a, $urandom, 5'($urandom),
                          2'($urandom), $urandom_range(0, 2), 0, $urandom);
                2: run_op(1'b1, 1'b0, $urandom, a, $urandom, 5'($urandom), 2'b01,
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
                default: run_op(1'b1, 1'b0, $urandom, a, $urandom, 5'($urandom), 2'b10,
                                0, 0, $urandom);
            endcase
        end

        // reset while waiting for a load response; stale rvalid afterwards
        mem_we_reg = 1'b1; mem_we_dmem = 1'b0; mem_pc = 32'h70; mem_rd = 32'h400;
        mem_rs2 = 32'h0; mem_rdst_id = 5'd11; mem_wbsel = 2'b01;
        dmem.dmem_gnt = 1'b1; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
        if (cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 1;
        push_exp(1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dmem.dmem_gnt = 1'b0;
        cnt_model = 0;
        push_exp(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        check_val("rst_mid_req", 32'(dmem.dmem_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_nop(32'h44, 5'd3);
        mem_we_reg = 1'b1;
        push_exp(1'b1, 5'd3, 32'h44, 1'b0);
        #1;
        check_val("post_rst_stall", 32'(mem_stall), 32'h0);
        check_val("post_rst_req", 32'(dmem.dmem_req), 32'h0);
        @(negedge clk);
        drive_nop(32'h48, 5'd4);
        mem_we_reg = 1'b1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hBAD0_BAD0;
        push_exp(1'b1, 5'd4, 32'h48, 1'b0);
        #1;
        check_val("stale_rvalid_stall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        drive_nop(32'h4C, 5'd6);
        push_exp(1'b0, 5'd6, 32'h4C, 1'b0);

        @(posedge clk);
        #2;
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
